// File: rtl/parity_pkg.sv
// parity_pkg: shared mode codes and FSM/owner types for the parity arbiter
package parity_pkg;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;
  typedef enum logic [1:0] {IDLE, CAPTURE, RESULT} state_t;
  typedef enum logic {OWN_GEN, OWN_CHK} owner_t;
endpackage

// File: rtl/parity_core.sv
// parity_core: combinational even-parity generate/check datapath
module parity_core
  import parity_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  input  logic              parity_in,
  output logic              parity_out,
  output logic              ok
);
  // the check result is only meaningful in check mode
  assign parity_out = ^data;
  assign ok = (mode == MODE_CHK) ? ~^{data, parity_in} : 1'b0;
endmodule

// File: rtl/parity_arbiter.sv
// parity_arbiter: round-robin sharing of one parity datapath between GEN and CHK clients
module parity_arbiter
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gen_req,
  input  logic [DATA_W-1:0] gen_data,
  output logic              gen_gnt,
  output logic              gen_done,
  output logic              gen_parity,
  input  logic              chk_req,
  input  logic [DATA_W-1:0] chk_data,
  input  logic              chk_parity_in,
  output logic              chk_gnt,
  output logic              chk_done,
  output logic              chk_ok,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);
  state_t             state_q, state_d;
  owner_t             last_q, last_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               pin_q, pin_d;
  logic               gen_gnt_q, gen_gnt_d, chk_gnt_q, chk_gnt_d;
  logic               gen_done_q, gen_done_d, chk_done_q, chk_done_d;
  logic               gen_parity_q, gen_parity_d, chk_ok_q, chk_ok_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               pick_chk, core_parity, core_ok;

  parity_core #(.DATA_W(DATA_W)) u_core (
    .data      (data_q),
    .mode      (mode_q),
    .parity_in (pin_q),
    .parity_out(core_parity),
    .ok        (core_ok)
  );

  // CHK wins only when alone or when GEN owned the datapath last
  assign pick_chk = chk_req && (!gen_req || last_q == OWN_GEN);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    mode_d       = mode_q;
    data_d       = data_q;
    pin_d        = pin_q;
    gen_gnt_d    = 1'b0;
    chk_gnt_d    = 1'b0;
    gen_done_d   = 1'b0;
    chk_done_d   = 1'b0;
    gen_parity_d = gen_parity_q;
    chk_ok_d     = chk_ok_q;
    err_d        = err_q;
    case (state_q)
      IDLE: if (gen_req || chk_req) begin
        state_d   = CAPTURE;
        last_d    = pick_chk ? OWN_CHK : OWN_GEN;
        mode_d    = pick_chk ? MODE_CHK : MODE_GEN;
        data_d    = pick_chk ? chk_data : gen_data;
        pin_d     = pick_chk & chk_parity_in;
        gen_gnt_d = !pick_chk;
        chk_gnt_d = pick_chk;
      end
      CAPTURE: begin
        state_d    = RESULT;
        gen_done_d = (mode_q == MODE_GEN);
        chk_done_d = (mode_q == MODE_CHK);
        if (mode_q == MODE_GEN) gen_parity_d = core_parity;
        else begin
          chk_ok_d = core_ok;
          if (!core_ok && !(&err_q)) err_d = err_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= OWN_CHK;
      mode_q       <= MODE_GEN;
      data_q       <= '0;
      pin_q        <= 1'b0;
      gen_gnt_q    <= 1'b0;
      chk_gnt_q    <= 1'b0;
      gen_done_q   <= 1'b0;
      chk_done_q   <= 1'b0;
      gen_parity_q <= 1'b0;
      chk_ok_q     <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      mode_q       <= mode_d;
      data_q       <= data_d;
      pin_q        <= pin_d;
      gen_gnt_q    <= gen_gnt_d;
      chk_gnt_q    <= chk_gnt_d;
      gen_done_q   <= gen_done_d;
      chk_done_q   <= chk_done_d;
      gen_parity_q <= gen_parity_d;
      chk_ok_q     <= chk_ok_d;
      err_q        <= err_d;
    end
  end

  assign gen_gnt    = gen_gnt_q;
  assign chk_gnt    = chk_gnt_q;
  assign gen_done   = gen_done_q;
  assign chk_done   = chk_done_q;
  assign gen_parity = gen_parity_q;
  assign chk_ok     = chk_ok_q;
  assign err_cnt    = err_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: doc/parity_arbiter.md
Name: parity_arbiter

Overview:
- Shares one 4-bit even-parity datapath between two requesters: a generate client (GEN) and a check client (CHK).
- Round-robin arbitration with registered grant; the datapath mode is set per transaction.
- Registered results with a one-cycle done pulse per client.
- Saturating error counter on CHK failures.
- Sits between the serial-link framing logic and the shared parity datapath.

Parameters:
- DATA_W, 4, operand width in bits (datapath is 4-bit; other values unsupported).
- CNT_W, 8, width of the saturating CHK error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- gen_req  input  1  GEN request; held high until gen_gnt.
- gen_data  input  DATA_W  GEN operand; sampled in the gen_gnt cycle.
- gen_gnt  output  1  one-cycle pulse: GEN operand captured.
- gen_done  output  1  one-cycle pulse: gen_parity valid.
- gen_parity  output  1  even-parity bit of the captured gen_data (XOR reduce).
- chk_req  input  1  CHK request; held high until chk_gnt.
- chk_data  input  DATA_W  CHK operand; sampled in the chk_gnt cycle.
- chk_parity_in  input  1  received parity bit; sampled with chk_data.
- chk_gnt  output  1  one-cycle pulse: CHK operands captured.
- chk_done  output  1  one-cycle pulse: chk_ok valid.
- chk_ok  output  1  1 when XNOR-reduce of {chk_data, chk_parity_in} is 1 (even total ones).
- err_cnt  output  CNT_W  count of CHK transactions with chk_ok=0; saturates.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE.
  - gen_gnt, chk_gnt, gen_done, chk_done, gen_parity, chk_ok = 0.
  - err_cnt=0, busy=0.
  - last_owner=CHK, so GEN wins the first tie.
- FSM states: IDLE, CAPTURE, RESULT.
- IDLE:
  - If any req is high at a clk edge, pick an owner and go to CAPTURE.
  - Owner selection: single requester wins; if both request, the client that is not last_owner wins.
- CAPTURE (1 cycle):
  - Owner's gnt=1.
  - Operand registers load the owner's data (and chk_parity_in for CHK).
  - mode is set: GEN=0, CHK=1.
  - last_owner updates.
  - Next state is RESULT.
- RESULT (1 cycle):
  - Owner's done=1.
  - The result register loads from the datapath.
  - For CHK with a failed check, err_cnt increments unless it equals 2^CNT_W-1.
  - Next state is IDLE.
- Latency: req high at edge N → gnt during cycle N+1 → done during cycle N+2.
  - Peak throughput is one transaction per 3 cycles.
- Result persistence:
  - gen_parity and chk_ok hold their last value until the owner's next RESULT.
  - The non-owner's result is unchanged.
- Requests:
  - A req deasserted before its gnt is dropped; no transaction, no error.
  - Requests arriving during CAPTURE/RESULT wait; they are evaluated in the next IDLE.
- Both reqs held continuously: grants strictly alternate GEN, CHK, GEN, ...
- Exactly one of gen_gnt/chk_gnt may be high in any cycle; likewise for done.
- The datapath drives defined 0/1 at all times; there are no high-Z outputs in this block.
- Reset mid-transaction: returns to IDLE immediately. No done pulse is issued for the aborted transaction, and err_cnt clears.

Decomposition:
- Package parity_pkg holds:
  - MODE_GEN=1'b0 and MODE_CHK=1'b1.
  - The state enum {IDLE, CAPTURE, RESULT}.
  - The owner enum {OWN_GEN, OWN_CHK}.
- Sub-module parity_core is the combinational shared datapath.
  - Inputs: data[DATA_W-1:0], mode, parity_in.
  - Outputs: parity_out = ^data; ok = ~^{data, parity_in}.
  - Both outputs are always driven, with no tri-state.
- The arbiter instantiates one parity_core fed from the operand registers.

Test Plan:
- GEN only, gen_data=4'b1011 → gen_gnt at N+1, gen_done at N+2 with gen_parity=1; chk outputs stay 0.
- CHK only, chk_data=4'b1011, chk_parity_in=1 → chk_ok=1, err_cnt=0.
  - Repeat with chk_parity_in=0 → chk_ok=0, err_cnt=1.
- Both reqs held high from reset for 12 cycles → grant order GEN, CHK, GEN, CHK at cycles 1, 4, 7, 10; never both gnt in the same cycle.
- CNT_W=2, four failing CHK transactions (chk_data=4'h0, chk_parity_in=1) → err_cnt reads 1, 2, 3, 3 (saturates).
- rst_n pulsed low in the CAPTURE cycle of a GEN transaction → no gen_done, busy=0, err_cnt=0.
  - A new gen_req afterwards wins the tie against chk_req (last_owner=CHK).
- gen_req raised for 1 cycle while a CHK transaction is in RESULT, then dropped → no GEN grant ever issued; busy falls after chk_done.
